fpu_issue_sequencer: RTL and testbench
======================================

Name: fpu_issue_sequencer

Overview:
- Sequences the multi-cycle FPU attached to the RISC pipeline EX stage.
- Accepts one FP operation at a time from EX and pulses the FPU start strobe.
- Counts the op-dependent latency, then issues a one-cycle FP register-file writeback.
- Generates fetch/decode stalls for structural hazards (second FP op) and data hazards (read of the pending destination register); integer instructions flow past it.

Parameters:
- LAT_ADD, 3: cycles from start to writeback for add/sub.
- LAT_MUL, 4: cycles for mul.
- LAT_DIV, 12: cycles for div.
- LAT_SQRT, 14: cycles for sqrt.
- LAT_CMP, 1: cycles for min/max/compare.
- All latency parameters must lie in 1..15; the counter is 4 bits.

Ports:
- clk in 1: clock, rising edge.
- rst_n in 1: asynchronous active-low reset.
- issue_valid in 1: EX stage holds an FP instruction.
- issue_op in 3: 000 add, 001 sub, 010 mul, 011 div, 100 sqrt, 101 cmp; 110/111 illegal.
- issue_rd in 5: FP destination register of the EX instruction.
- flush_e in 1: EX stage is being flushed (branch taken) this cycle.
- fp_op_d in 1: ID instruction is an FP operation.
- fp_src_d in 1: ID instruction reads FP registers.
- rs1_d in 5: ID FP source register 1.
- rs2_d in 5: ID FP source register 2.
- fpu_start out 1: one-cycle start strobe to the FPU.
- fpu_op out 3: operation code to the FPU.
- busy out 1: an operation is in flight.
- stall_f out 1: hold the PC.
- stall_d out 1: hold the IF/ID register.
- wb_valid out 1: FP register-file write enable, one cycle.
- wb_rd out 5: FP writeback register.
- illegal_op out 1: one-cycle pulse for an illegal issue_op.

Behaviour:

Reset:
- rst_n=0 forces state IDLE and clears the counter, the latched op and the latched rd.
- All outputs read 0 while reset is asserted and in the first cycle after release.
- Reset during BUSY abandons the operation; no wb_valid is produced.

Acceptance:
- accept = issue_valid & !flush_e & issue_op legal & state in {IDLE, WB}.
- On accept, fpu_start=1 and fpu_op=issue_op in the same cycle (combinational).
- On accept, issue_op and issue_rd are latched and the counter is loaded with LAT(op).
- issue_valid with an illegal op (and no flush): illegal_op=1 for that cycle, no start, state unchanged.
- issue_valid while BUSY cannot occur, because stall_d holds the second FP op in ID. If it does occur, it is ignored.

State machine IDLE / BUSY / WB:
- IDLE: accept with LAT=1 goes to WB; accept with LAT>1 goes to BUSY.
- BUSY: the counter decrements each cycle. When the counter would reach 1, the next state is WB.
- WB: wb_valid=1 and wb_rd=latched rd. The next state is IDLE, unless a new accept occurs in the same cycle (back-to-back); then the FSM reloads and goes to BUSY or WB.
- Timing rule: wb_valid is asserted exactly LAT cycles after the fpu_start cycle.
- busy = (state != IDLE) | accept.

Flush:
- flush_e in the accept cycle suppresses acceptance.
- flush_e while BUSY or WB has no effect; the in-flight op completes and writes back.

Hazard stalls:
- pending is true in the accept cycle and in every BUSY cycle. It is false in the WB cycle (the FP regfile writes first half and reads second half) and in IDLE.
- pend_rd = issue_rd in the accept cycle, otherwise the latched rd.
- stall_d = pending & (fp_op_d | (fp_src_d & (rs1_d==pend_rd | rs2_d==pend_rd))).
- stall_f = stall_d.
- Register f0 is a real FP register and is compared like any other.

Test Plan:
1. Add: reset, then issue_valid=1, op=000, rd=5 at cycle 10 -> fpu_start=1 at cycle 10; busy for cycles 10..13; wb_valid=1, wb_rd=5 at cycle 13 only.
2. Dependency stall: during scenario 1, ID holds fp_src_d=1, rs1_d=5 -> stall_d=stall_f=1 in cycles 10..12; 0 in cycle 13.
3. Structural stall and back-to-back: div rd=3 at cycle 0 (LAT 12); ID holds FP mul rd=4 -> stall_d high in cycles 0..11; mul accepted at cycle 12 (the WB cycle of div); wb_rd=3 at cycle 12, wb_rd=4 at cycle 16.
4. Flush and illegal: issue_valid=1 with flush_e=1 -> no fpu_start, state stays IDLE. Then op=111 -> illegal_op pulses once, no start, busy=0.
5. Cmp (LAT 1): op=101, rd=9 at cycle 0 -> fpu_start at cycle 0, wb_valid at cycle 1, busy=0 at cycle 2. An integer instruction in ID (fp_op_d=0, fp_src_d=0) never sees stall_d.
6. Reset mid-op: assert rst_n=0 at cycle 3 of sqrt rd=7 -> busy, wb_valid and stall_d go 0 immediately. After release, no writeback of rd 7 ever appears.

Source files
------------

// File: rtl/fpu_issue_sequencer_if.sv
// Handshake bundle between the EX/ID pipeline stages and the FPU issue sequencer.
// The pipeline is the master; the sequencer is the slave.
interface fpu_issue_sequencer_if;
   logic       issue_valid;
   logic [2:0] issue_op;
   logic [4:0] issue_rd;
   logic       flush_e;
   logic       fp_op_d;
   logic       fp_src_d;
   logic [4:0] rs1_d;
   logic [4:0] rs2_d;
   logic       fpu_start;
   logic [2:0] fpu_op;
   logic       busy;
   logic       stall_f;
   logic       stall_d;
   logic       wb_valid;
   logic [4:0] wb_rd;
   logic       illegal_op;

   modport master (
      output issue_valid, issue_op, issue_rd, flush_e, fp_op_d, fp_src_d, rs1_d, rs2_d,
      input  fpu_start, fpu_op, busy, stall_f, stall_d, wb_valid, wb_rd, illegal_op
   );

   modport slave (
      input  issue_valid, issue_op, issue_rd, flush_e, fp_op_d, fp_src_d, rs1_d, rs2_d,
      output fpu_start, fpu_op, busy, stall_f, stall_d, wb_valid, wb_rd, illegal_op
   );
endinterface

// File: rtl/fpu_issue_sequencer.sv
// Single-op FPU issue sequencer: starts the FPU, times the op latency, issues the
// FP writeback and raises fetch/decode stalls for structural and data hazards.
//
//   state | meaning
//   IDLE  | no FP op in flight; a legal issue is accepted
//   BUSY  | op in flight, latency counter running down
//   WB    | writeback cycle; a new op may be accepted back-to-back
module fpu_issue_sequencer #(
   parameter int unsigned LAT_ADD  = 3,
   parameter int unsigned LAT_MUL  = 4,
   parameter int unsigned LAT_DIV  = 12,
   parameter int unsigned LAT_SQRT = 14,
   parameter int unsigned LAT_CMP  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   fpu_issue_sequencer_if.slave  seq
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   state_t     state_q;
   logic [3:0] cnt_q;
   logic [2:0] op_q;
   logic [4:0] rd_q;
   logic       active_q;

   logic       op_legal;
   logic       can_issue;
   logic       accept;
   logic       pending;
   logic [4:0] pend_rd;
   logic [3:0] lat_sel;

   always_comb begin
      lat_sel = 4'd1;
      unique case (seq.issue_op)
         3'b000, 3'b001: lat_sel = 4'(LAT_ADD);
         3'b010:         lat_sel = 4'(LAT_MUL);
         3'b011:         lat_sel = 4'(LAT_DIV);
         3'b100:         lat_sel = 4'(LAT_SQRT);
         3'b101:         lat_sel = 4'(LAT_CMP);
         default:        lat_sel = 4'd1;
      endcase
   end

   // active_q keeps every output quiet for the first cycle after reset release
   assign op_legal  = (seq.issue_op <= 3'd5);
   assign can_issue = active_q & seq.issue_valid & ~seq.flush_e & (state_q != ST_BUSY);
   assign accept    = can_issue & op_legal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         op_q     <= 3'd0;
         rd_q     <= 5'd0;
         active_q <= 1'b0;
      end else begin
         active_q <= 1'b1;
         unique case (state_q)
            ST_IDLE, ST_WB: begin
               if (accept) begin
                  op_q    <= seq.issue_op;
                  rd_q    <= seq.issue_rd;
                  cnt_q   <= lat_sel;
                  state_q <= (lat_sel <= 4'd1) ? ST_WB : ST_BUSY;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q <= 4'd2) state_q <= ST_WB;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // WB is excluded from pending: the regfile writes before it is read in that cycle
   assign pending = accept | (state_q == ST_BUSY);
   assign pend_rd = accept ? seq.issue_rd : rd_q;

   assign seq.stall_d    = pending & (seq.fp_op_d |
                           (seq.fp_src_d & ((seq.rs1_d == pend_rd) | (seq.rs2_d == pend_rd))));
   assign seq.stall_f    = seq.stall_d;
   assign seq.fpu_start  = accept;
   assign seq.fpu_op     = accept ? seq.issue_op : ((state_q != ST_IDLE) ? op_q : 3'd0);
   assign seq.busy       = (state_q != ST_IDLE) | accept;
   assign seq.wb_valid   = (state_q == ST_WB);
   assign seq.wb_rd      = (state_q == ST_WB) ? rd_q : 5'd0;
   assign seq.illegal_op = can_issue & ~op_legal;

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// Randomized bench for fpu_issue_sequencer against a cycle-count reference model
// that tracks the in-flight op by its absolute writeback cycle.
module tb_fpu_issue_sequencer;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;
   int   cyc;

   fpu_issue_sequencer_if bus();

   fpu_issue_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .seq   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   bit       live;
   bit       inflight;
   int       wb_time;
   int       m_rd;
   int       m_op;

   task automatic check_val(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int lat_of(input int op);
      case (op)
         0, 1:    return 3;
         2:       return 4;
         3:       return 12;
         4:       return 14;
         default: return 1;
      endcase
   endfunction

   task automatic step(input bit r, input bit iv, input int op, input int rd, input bit fl,
                       input bit fpop, input bit fpsrc, input int rs1, input int rs2);
      bit gate, legal, idleish, acc, ill, wbv, pend, stl, bsy;
      int prd, eop;
      @(negedge clk);
      rst_n            = r;
      bus.issue_valid  = iv;
      bus.issue_op     = 3'(op);
      bus.issue_rd     = 5'(rd);
      bus.flush_e      = fl;
      bus.fp_op_d      = fpop;
      bus.fp_src_d     = fpsrc;
      bus.rs1_d        = 5'(rs1);
      bus.rs2_d        = 5'(rs2);
      if (!r) begin
         live     = 0;
         inflight = 0;
      end
      gate    = live;
      legal   = (op < 6);
      idleish = !inflight || (cyc == wb_time);
      acc     = gate && iv && !fl && legal && idleish;
      ill     = gate && iv && !fl && !legal && idleish;
      wbv     = gate && inflight && (cyc == wb_time);
      pend    = acc || (gate && inflight && cyc < wb_time);
      prd     = acc ? rd : m_rd;
      stl     = pend && (fpop || (fpsrc && (rs1 == prd || rs2 == prd)));
      bsy     = acc || (gate && inflight);
      eop     = acc ? op : ((gate && inflight) ? m_op : 0);
      #1;
      check_val("fpu_start", int'(bus.fpu_start), int'(acc));
      check_val("fpu_op", int'(bus.fpu_op), eop);
      check_val("busy", int'(bus.busy), int'(bsy));
      check_val("stall_d", int'(bus.stall_d), int'(stl));
      check_val("stall_f", int'(bus.stall_f), int'(stl));
      check_val("wb_valid", int'(bus.wb_valid), int'(wbv));
      check_val("wb_rd", int'(bus.wb_rd), wbv ? m_rd : 0);
      check_val("illegal_op", int'(bus.illegal_op), int'(ill));
      if (wbv) inflight = 0;
      if (acc) begin
         inflight = 1;
         wb_time  = cyc + lat_of(op);
         m_rd     = rd;
         m_op     = op;
      end
      if (r) live = 1;
      cyc++;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int op, rd, rs1, rs2;
      bit iv, fl, fpop, fpsrc, r;
      n_cmp = 0; n_bad = 0; cyc = 0;
      live = 0; inflight = 0; wb_time = 0; m_rd = 0; m_op = 0;
      rst_n = 1'b0;
      bus.issue_valid = 0; bus.issue_op = 0; bus.issue_rd = 0; bus.flush_e = 0;
      bus.fp_op_d = 0; bus.fp_src_d = 0; bus.rs1_d = 0; bus.rs2_d = 0;

      for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 1, 1, 1, 1);
      // release cycle with a pending issue: must stay silent
      step(1, 1, 0, 1, 0, 1, 1, 1, 1);
      idle_cycles(6);

      // add rd=5 with a dependent reader of f5 in ID
      step(1, 1, 0, 5, 0, 0, 1, 5, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 1, 5, 0);

      // div rd=3, then mul rd=4 held in ID until the div writeback cycle
      step(1, 1, 3, 3, 0, 1, 0, 0, 0);
      for (int i = 0; i < 11; i++) step(1, 1, 2, 4, 0, 1, 0, 0, 0);
      step(1, 1, 2, 4, 0, 0, 0, 0, 0);
      idle_cycles(5);

      // flushed issue, illegal op, cmp with f0 dependency and integer ID instruction
      step(1, 1, 0, 2, 1, 0, 0, 0, 0);
      step(1, 1, 7, 2, 0, 0, 0, 0, 0);
      step(1, 1, 6, 2, 0, 0, 0, 0, 0);
      step(1, 1, 5, 0, 0, 0, 1, 0, 3);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);

      // sqrt rd=7 abandoned by reset, flush while busy has no effect
      step(1, 1, 4, 7, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1, 7, 7);
      step(0, 0, 0, 0, 0, 0, 1, 7, 7);
      step(1, 0, 0, 0, 0, 0, 1, 7, 7);
      idle_cycles(20);

      for (int i = 0; i < 3000; i++) begin
         r     = ($urandom_range(0, 299) != 0);
         iv    = ($urandom_range(0, 9) < 4);
         op    = $urandom_range(0, 7);
         rd    = $urandom_range(0, 31);
         fl    = ($urandom_range(0, 6) == 0);
         fpop  = ($urandom_range(0, 3) == 0);
         fpsrc = ($urandom_range(0, 1) == 1);
         rs1   = ($urandom_range(0, 3) == 0) ? m_rd : $urandom_range(0, 31);
         rs2   = ($urandom_range(0, 3) == 0) ? m_rd : $urandom_range(0, 31);
         step(r, iv, op, rd, fl, fpop, fpsrc, rs1, rs2);
      end
      idle_cycles(16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
